// File: rtl/hex_char_parser.sv
// ASCII hex-digit stream to binary word parser.
// Digits accumulate MSB-first; CR emits the word, space is ignored, anything else is rejected.
module hex_char_parser #(
  parameter int unsigned DIGITS = 4
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [7:0]            char_in,
  input  logic                  char_valid,
  output logic                  char_ready,
  output logic [4*DIGITS-1:0]   word_out,
  output logic                  word_valid,
  input  logic                  word_ready,
  output logic                  err,
  output logic [3:0]            digit_count
);

  localparam int unsigned W    = 4 * DIGITS;
  localparam int unsigned CW   = 4;
  localparam logic [7:0]  CH_CR = 8'h0d;
  localparam logic [7:0]  CH_SP = 8'h20;

  typedef enum logic {ACCUM = 1'b0, OUT = 1'b1} state_t;

  state_t          state;
  state_t          state_nxt;
  logic [W-1:0]    acc;
  logic [CW-1:0]   cnt;
  logic            is_hex;
  logic [3:0]      nibble;
  logic            accept;
  logic            full;

  // ASCII hex digit decode
  always_comb begin
    is_hex = 1'b0;
    nibble = 4'h0;
    if (char_in >= 8'h30 && char_in <= 8'h39) begin
      is_hex = 1'b1;
      nibble = 4'(char_in - 8'h30);
    end else if (char_in >= 8'h41 && char_in <= 8'h46) begin
      is_hex = 1'b1;
      nibble = 4'(char_in - 8'h37);
    end else if (char_in >= 8'h61 && char_in <= 8'h66) begin
      is_hex = 1'b1;
      nibble = 4'(char_in - 8'h57);
    end
  end

  assign accept      = char_valid && char_ready;
  assign full        = (cnt == CW'(DIGITS));
  assign digit_count = cnt;

  // State register
  always_ff @(posedge clk) begin
    if (!reset_n) state <= ACCUM;
    else          state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      ACCUM: if (accept && char_in == CH_CR && cnt != '0) state_nxt = OUT;
      OUT:   if (word_ready) state_nxt = ACCUM;
      default: state_nxt = ACCUM;
    endcase
  end

  // Handshake outputs decoded from the state register
  always_comb begin
    char_ready = 1'b0;
    word_valid = 1'b0;
    case (state)
      ACCUM:   char_ready = 1'b1;
      OUT:     word_valid = 1'b1;
      default: char_ready = 1'b1;
    endcase
  end

  // Accumulator, count, output word and error pulse
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      acc      <= '0;
      cnt      <= '0;
      word_out <= '0;
      err      <= 1'b0;
    end else begin
      err <= 1'b0;
      if (state == ACCUM && accept) begin
        if (is_hex) begin
          if (!full) begin
            acc <= W'({acc, nibble});
            cnt <= cnt + CW'(1);
          end else begin
            err <= 1'b1;
            acc <= '0;
            cnt <= '0;
          end
        end else if (char_in == CH_CR) begin
          if (cnt != '0) word_out <= acc;
        end else if (char_in != CH_SP) begin
          err <= 1'b1;
          acc <= '0;
          cnt <= '0;
        end
      end else if (state == OUT && word_ready) begin
        acc <= '0;
        cnt <= '0;
      end
    end
  end

endmodule

// File: tb/tb_hex_char_parser.sv
// Self-checking bench for hex_char_parser: directed sequences plus random
// character streams compared every cycle against a behavioural model.
module tb_hex_char_parser;

  localparam int unsigned D = 4;

  logic              clk = 1'b0;
  logic              reset_n;
  logic [7:0]        char_in;
  logic              char_valid;
  logic              char_ready;
  logic [4*D-1:0]    word_out;
  logic              word_valid;
  logic              word_ready;
  logic              err;
  logic [3:0]        digit_count;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state
  bit m_out;
  int m_cnt;
  int m_val;
  int m_word;
  bit m_err;

  hex_char_parser #(.DIGITS(D)) dut (
    .clk(clk), .reset_n(reset_n), .char_in(char_in), .char_valid(char_valid),
    .char_ready(char_ready), .word_out(word_out), .word_valid(word_valid),
    .word_ready(word_ready), .err(err), .digit_count(digit_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got=0x%0h expected=0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int hex_value(input logic [7:0] ch);
    if (ch >= "0" && ch <= "9") return int'(ch) - 48;
    if (ch >= "A" && ch <= "F") return int'(ch) - 65 + 10;
    if (ch >= "a" && ch <= "f") return int'(ch) - 97 + 10;
    return -1;
  endfunction

  // Model update for one clock edge using the inputs present at that edge
  task automatic model_step(input bit v, input logic [7:0] ch, input bit wr, input bit rn);
    int h;
    if (!rn) begin
      m_out = 0; m_cnt = 0; m_val = 0; m_word = 0; m_err = 0;
      return;
    end
    m_err = 0;
    if (m_out) begin
      if (wr) begin
        m_out = 0; m_cnt = 0; m_val = 0;
      end
    end else if (v) begin
      h = hex_value(ch);
      if (h >= 0) begin
        if (m_cnt < D) begin
          m_val = m_val * 16 + h;
          m_cnt = m_cnt + 1;
        end else begin
          m_err = 1; m_val = 0; m_cnt = 0;
        end
      end else if (ch == 8'h0d) begin
        if (m_cnt > 0) begin
          m_word = m_val; m_out = 1;
        end
      end else if (ch != 8'h20) begin
        m_err = 1; m_val = 0; m_cnt = 0;
      end
    end
  endtask

  // One cycle: apply inputs, clock, then compare every output against the model
  task automatic cycle(input bit v, input logic [7:0] ch, input bit wr, input bit rn);
    char_valid = v;
    char_in    = ch;
    word_ready = wr;
    reset_n    = rn;
    @(posedge clk);
    model_step(v, ch, wr, rn);
    #1;
    check("char_ready",  32'(char_ready),  32'(!m_out));
    check("word_valid",  32'(word_valid),  32'(m_out));
    check("word_out",    32'(word_out),    32'(m_word));
    check("err",         32'(err),         32'(m_err));
    check("digit_count", 32'(digit_count), 32'(m_cnt));
  endtask

  task automatic send_str(input string s, input bit wr);
    for (int i = 0; i < s.len(); i++) cycle(1'b1, s[i], wr, 1'b1);
  endtask

  function automatic logic [7:0] rand_char();
    int unsigned sel;
    string hx;
    hx = "0123456789abcdefABCDEF";
    sel = $urandom_range(0, 9);
    if (sel < 6) return hx[$urandom_range(0, hx.len() - 1)];
    if (sel < 8) return 8'h0d;
    if (sel < 9) return 8'h20;
    return 8'($urandom_range(0, 255));
  endfunction

  initial begin
    char_in = 8'h00; char_valid = 1'b0; word_ready = 1'b0; reset_n = 1'b0;
    cycle(1'b0, 8'h00, 1'b0, 1'b0);
    cycle(1'b0, 8'h00, 1'b0, 1'b0);
    check("reset_ready", 32'(char_ready), 32'd1);

    // "1aF0" CR with word_ready high
    send_str("1aF0", 1'b1);
    cycle(1'b1, 8'h0d, 1'b1, 1'b1);
    check("seq1_word", 32'(word_out), 32'h1AF0);
    check("seq1_valid", 32'(word_valid), 32'd1);
    cycle(1'b0, 8'h00, 1'b1, 1'b1);
    check("seq1_ready_back", 32'(char_ready), 32'd1);

    // "7" CR with downstream stalled for five cycles
    send_str("7", 1'b0);
    cycle(1'b1, 8'h0d, 1'b0, 1'b1);
    for (int i = 0; i < 5; i++) begin
      cycle(1'b1, "3", 1'b0, 1'b1);
      check("seq2_hold", 32'(word_out), 32'h0007);
      check("seq2_stall", 32'(char_ready), 32'd0);
    end
    cycle(1'b0, 8'h00, 1'b1, 1'b1);
    check("seq2_drop", 32'(word_valid), 32'd0);

    // Overflow on the fifth digit
    send_str("1234", 1'b1);
    cycle(1'b1, "5", 1'b1, 1'b1);
    check("seq3_err", 32'(err), 32'd1);
    check("seq3_cnt", 32'(digit_count), 32'd0);
    send_str("9", 1'b1);
    cycle(1'b1, 8'h0d, 1'b0, 1'b1);
    check("seq3_word", 32'(word_out), 32'h0009);
    cycle(1'b0, 8'h00, 1'b1, 1'b1);

    // Invalid character mid-word
    send_str("1", 1'b1);
    cycle(1'b1, "G", 1'b1, 1'b1);
    check("seq4_err", 32'(err), 32'd1);
    send_str("2", 1'b1);
    cycle(1'b1, 8'h0d, 1'b0, 1'b1);
    check("seq4_word", 32'(word_out), 32'h0002);
    cycle(1'b0, 8'h00, 1'b1, 1'b1);

    // CR and spaces with no digits
    cycle(1'b1, 8'h0d, 1'b1, 1'b1);
    send_str("  ", 1'b1);
    check("seq5_err", 32'(err), 32'd0);
    check("seq5_valid", 32'(word_valid), 32'd0);
    check("seq5_cnt", 32'(digit_count), 32'd0);

    // Reset mid-word discards partial digits silently
    send_str("AB", 1'b1);
    cycle(1'b1, "D", 1'b1, 1'b0);
    check("seq6_rst_err", 32'(err), 32'd0);
    send_str("C", 1'b1);
    cycle(1'b1, 8'h0d, 1'b0, 1'b1);
    check("seq6_word", 32'(word_out), 32'h000C);
    cycle(1'b0, 8'h00, 1'b0, 1'b0);
    check("seq6_rst_out", 32'(word_valid), 32'd0);

    // Random streams with random backpressure and occasional reset
    for (int i = 0; i < 3000; i++) begin
      cycle(1'($urandom_range(0, 3) != 0), rand_char(),
            1'($urandom_range(0, 2) == 0), 1'($urandom_range(0, 99) != 0));
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
